// File: rtl/titan_clint.sv
// Machine-mode local interruptor: free-running 64-bit mtime, mtimecmp and msip
// behind a single-cycle-ack Wishbone slave, driving the core's MTIP/MSIP lines.
module titan_clint #(
   parameter int unsigned TICK_DIV  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] wb_addr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        xint_mtip_o,
   output logic        xint_msip_o
);

   localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

   localparam logic [2:0] OFF_MSIP     = 3'd0;
   localparam logic [2:0] OFF_MTCMP_LO = 3'd1;
   localparam logic [2:0] OFF_MTCMP_HI = 3'd2;
   localparam logic [2:0] OFF_MTIME_LO = 3'd3;
   localparam logic [2:0] OFF_MTIME_HI = 3'd4;

   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic [31:0]   dat_q, dat_d;
   logic          mtip_q, mtip_d;

   logic          req;
   logic          in_win;
   logic          aligned;
   logic          mapped;
   logic [2:0]    off;
   logic          hit;
   logic          wr;
   logic          rd;
   logic          tick;
   logic [31:0]   rdata;

   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
      end
      return res;
   endfunction

   // A request is only accepted while no response is being presented.
   always_comb begin
      req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
      in_win  = (wb_addr_i[31:5] == BASE_ADDR[31:5]);
      aligned = (wb_addr_i[1:0] == 2'b00);
      off     = wb_addr_i[4:2];
      mapped  = (off <= OFF_MTIME_HI);
      hit     = req & in_win & aligned & mapped;
      wr      = hit & wb_we_i & (|wb_sel_i);
      rd      = hit & ~wb_we_i;
   end

   always_comb begin
      rdata = '0;
      unique case (off)
         OFF_MSIP:     rdata = {31'd0, msip_q};
         OFF_MTCMP_LO: rdata = mtimecmp_q[31:0];
         OFF_MTCMP_HI: rdata = mtimecmp_q[63:32];
         OFF_MTIME_LO: rdata = mtime_q[31:0];
         OFF_MTIME_HI: rdata = mtime_q[63:32];
         default:      rdata = '0;
      endcase
   end

   always_comb begin
      tick    = (presc_q == PRESC_TC);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // A bus write to either mtime half suppresses that cycle's increment entirely.
   always_comb begin
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr && off == OFF_MTIME_LO) begin
         mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
      end else if (wr && off == OFF_MTIME_HI) begin
         mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
      end
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      if (wr && off == OFF_MTCMP_LO) begin
         mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
      end else if (wr && off == OFF_MTCMP_HI) begin
         mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
      end
   end

   always_comb begin
      msip_d = msip_q;
      if (wr && off == OFF_MSIP && wb_sel_i[0]) msip_d = wb_dat_i[0];
   end

   always_comb begin
      ack_d  = hit;
      err_d  = req & ~hit;
      dat_d  = rd ? rdata : '0;
      mtip_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         presc_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
         mtip_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         presc_q    <= presc_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         mtip_q     <= mtip_d;
      end
   end

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign xint_mtip_o = mtip_q;
   assign xint_msip_o = msip_q;

endmodule

// File: tb/tb_titan_clint.sv
// Scoreboard bench for titan_clint: one instance with TICK_DIV=1 and one with
// TICK_DIV=4 share the bus wires; each has its own cycle line and response queue.
module tb_titan_clint;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] wb_addr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we;
   logic        wb_stb;
   logic        cyc1, cyc4;

   logic [31:0] dat1, dat4;
   logic        ack1, ack4, err1, err4;
   logic        mtip1, mtip4, msip1, msip4;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];

   titan_clint #(.TICK_DIV(1), .BASE_ADDR(BASE)) dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .wb_addr_i(wb_addr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
      .wb_cyc_i(cyc1), .wb_stb_i(wb_stb),
      .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1),
      .xint_mtip_o(mtip1), .xint_msip_o(msip1)
   );

   titan_clint #(.TICK_DIV(4), .BASE_ADDR(BASE)) dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .wb_addr_i(wb_addr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
      .wb_cyc_i(cyc4), .wb_stb_i(wb_stb),
      .wb_dat_o(dat4), .wb_ack_o(ack4), .wb_err_o(err4),
      .xint_mtip_o(mtip4), .xint_msip_o(msip4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_rsp(input string who, input logic ack, input logic err,
                            input logic [31:0] dat, inout exp_t q[$]);
      exp_t e;
      n_checks++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL %s unexpected response: ack=%0b err=%0b dat=%0h", who, ack, err, dat);
      end else begin
         e = q.pop_front();
         if (ack !== ~e.err || err !== e.err || dat !== e.dat) begin
            n_fail++;
            $display("FAIL %s response: ack=%0b err=%0b dat=%0h, expected ack=%0b err=%0b dat=%0h",
                     who, ack, err, dat, ~e.err, e.err, e.dat);
         end
      end
   endtask

   // Monitor: every presented response must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ack1 || err1) check_rsp("dut1", ack1, err1, dat1, q1);
         if (ack4 || err4) check_rsp("dut4", ack4, err4, dat4, q4);
      end
   end

   task automatic issue(input bit tgt4, input logic [31:0] addr, input bit we,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input bit exp_err, input logic [31:0] exp_dat, input bit expect_rsp);
      exp_t e;
      @(negedge clk);
      wb_addr = addr;
      wb_dat  = dat;
      wb_sel  = sel;
      wb_we   = we;
      wb_stb  = 1'b1;
      cyc1    = ~tgt4;
      cyc4    = tgt4;
      if (expect_rsp) begin
         e.err = exp_err;
         e.dat = exp_dat;
         if (tgt4) q4.push_back(e);
         else      q1.push_back(e);
      end
      @(posedge clk);
      #1;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      cyc1   = 1'b0;
      cyc4   = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr1(input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel,
                      input bit exp_err);
      issue(1'b0, addr, 1'b1, dat, sel, exp_err, 32'd0, 1'b1);
      settle();
   endtask

   task automatic rd(input bit tgt4, input logic [31:0] addr, input bit exp_err,
                     input logic [31:0] exp_dat);
      issue(tgt4, addr, 1'b0, 32'd0, 4'h0, exp_err, exp_dat, 1'b1);
      settle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      wb_addr = '0;
      wb_dat  = '0;
      wb_sel  = '0;
      wb_we   = 1'b0;
      wb_stb  = 1'b0;
      cyc1    = 1'b0;
      cyc4    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ack", {62'd0, ack1, err1}, 64'd0);
      chk("reset dat", {32'd0, dat1}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running count after reset release
      repeat (10) @(posedge clk);
      #1;
      chk("idle mtip", {63'd0, mtip1}, 64'd0);
      chk("idle msip", {63'd0, msip1}, 64'd0);
      rd(1'b0, BASE + 32'h0C, 1'b0, 32'd10);
      repeat (28) @(posedge clk);
      rd(1'b1, BASE + 32'h0C, 1'b0, 32'd10);
      rd(1'b1, BASE + 32'h10, 1'b0, 32'd0);

      // Timer compare: mtime restarted at 0, compare at 20
      wr1(BASE + 32'h0C, 32'd0, 4'hF, 1'b0);
      wr1(BASE + 32'h08, 32'd0, 4'hF, 1'b0);
      wr1(BASE + 32'h04, 32'd20, 4'hF, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      chk("mtip before", {63'd0, mtip1}, 64'd0);
      @(posedge clk);
      #1;
      chk("mtip rise", {63'd0, mtip1}, 64'd1);
      issue(1'b0, BASE + 32'h08, 1'b1, 32'd1, 4'hF, 1'b0, 32'd0, 1'b1);
      chk("mtip hold", {63'd0, mtip1}, 64'd1);
      settle();
      chk("mtip clear", {63'd0, mtip1}, 64'd0);

      // Software interrupt
      issue(1'b0, BASE, 1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0, 32'd0, 1'b1);
      chk("msip set", {63'd0, msip1}, 64'd1);
      settle();
      rd(1'b0, BASE, 1'b0, 32'h1);
      wr1(BASE, 32'hFFFF_FFFF, 4'b1110, 1'b0);
      chk("msip upper lanes", {63'd0, msip1}, 64'd1);
      wr1(BASE, 32'h0, 4'b0001, 1'b0);
      chk("msip clear", {63'd0, msip1}, 64'd0);
      wr1(BASE, 32'h1, 4'b0000, 1'b0);
      chk("msip sel0", {63'd0, msip1}, 64'd0);

      // Byte write to mtime lo while the tick would carry into hi
      wr1(BASE + 32'h0C, 32'hFFFF_FFFE, 4'hF, 1'b0);
      wr1(BASE + 32'h0C, 32'h0000_0010, 4'b0001, 1'b0);
      rd(1'b0, BASE + 32'h10, 1'b0, 32'd0);
      rd(1'b0, BASE + 32'h0C, 1'b0, 32'hFFFF_FF13);

      // Low-word wrap carries into hi
      wr1(BASE + 32'h10, 32'd0, 4'hF, 1'b0);
      wr1(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd(1'b0, BASE + 32'h10, 1'b0, 32'd1);
      rd(1'b0, BASE + 32'h0C, 1'b0, 32'd2);

      // Error responses
      rd(1'b0, BASE + 32'h14, 1'b1, 32'd0);
      wr1(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1);
      wr1(BASE + 32'h02, 32'h1, 4'hF, 1'b1);
      chk("msip misaligned", {63'd0, msip1}, 64'd0);
      wr1(32'h0300_0000, 32'h1, 4'hF, 1'b1);
      chk("msip outside", {63'd0, msip1}, 64'd0);
      rd(1'b0, BASE + 32'h0E, 1'b1, 32'd0);
      rd(1'b0, BASE + 32'h20, 1'b1, 32'd0);
      wr1(BASE + 32'h06, 32'h0, 4'hF, 1'b1);
      rd(1'b0, BASE + 32'h04, 1'b0, 32'd20);
      rd(1'b0, BASE + 32'h08, 1'b0, 32'd1);

      // Reset while a write response is pending
      issue(1'b0, BASE, 1'b1, 32'h1, 4'b0001, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ack gone", {62'd0, ack1, err1}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      rd(1'b0, BASE + 32'h0C, 1'b0, 32'd3);
      rd(1'b0, BASE, 1'b0, 32'd0);
      rd(1'b0, BASE + 32'h04, 1'b0, 32'hFFFF_FFFF);
      rd(1'b0, BASE + 32'h08, 1'b0, 32'hFFFF_FFFF);
      rd(1'b0, BASE + 32'h10, 1'b0, 32'd0);
      chk("post-reset msip", {63'd0, msip1}, 64'd0);
      chk("post-reset mtip", {63'd0, mtip1}, 64'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("dut1 responses outstanding", 64'(q1.size()), 64'd0);
      chk("dut4 responses outstanding", 64'(q4.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
